// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer and the 4-bit ALU datapath.
package alu_seq_pkg;

    localparam int ALU_W = 4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef logic [1:0] alu_seq_state_t;

    localparam alu_seq_state_t ST_IDLE = 2'd0;
    localparam alu_seq_state_t ST_EXEC = 2'd1;
    localparam alu_seq_state_t ST_RESP = 2'd2;

endpackage

// File: rtl/alu_4bit.sv
// Combinational 4-bit ALU: add/sub wrap modulo 2^ALU_W, no carry or borrow out.
module alu_4bit
    import alu_seq_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic [1:0]       op,
    output logic [ALU_W-1:0] result,
    output logic             zero
);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Valid/ready front-end around alu_4bit: accept, execute one cycle, hold response.
// Optional accumulator operand source is enabled by defining ALU_SEQ_ACC_EN.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int W = ALU_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    input  logic         cmd_use_acc,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_result,
    output logic         rsp_zero,
    output logic [7:0]   op_count
);

    alu_seq_state_t state;
    logic [1:0]     op_reg;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [W-1:0]   a_sel;
    logic [W-1:0]   alu_result;
    logic           alu_zero;

    alu_4bit u_alu (
        .a      (a_reg),
        .b      (b_reg),
        .op     (op_reg),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // Ready is held low while reset is asserted so nothing is accepted in that cycle.
    assign cmd_ready = (state == ST_IDLE) && !rst;
    assign rsp_valid = (state == ST_RESP);

`ifdef ALU_SEQ_ACC_EN
    logic [W-1:0] acc;

    assign a_sel = cmd_use_acc ? acc : cmd_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (state == ST_EXEC) begin
            acc <= alu_result;
        end
    end
`else
    logic unused_use_acc;

    assign a_sel          = cmd_a;
    assign unused_use_acc = cmd_use_acc;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_reg <= cmd_op;
                        a_reg  <= a_sel;
                        b_reg  <= cmd_b;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        op_count <= op_count + 8'd1;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
